// File: rtl/cpu_v2_pkg.sv
// cpu_v2_pkg: opcode and state encodings shared by the cpu_v2 core and its ALU.
// Revision: 1.0
`default_nettype none

package cpu_v2_pkg;

  localparam int OPCODE_BASE_WIDTH = 4;

  typedef enum logic [OPCODE_BASE_WIDTH-1:0] {
    OP_NOP    = 4'h0,
    OP_LDI    = 4'h1,
    OP_ADD    = 4'h2,
    OP_SUB    = 4'h3,
    OP_AND    = 4'h4,
    OP_OR     = 4'h5,
    OP_XOR    = 4'h6,
    OP_ADDI   = 4'h7,
    OP_IN     = 4'h8,
    OP_OUT    = 4'h9,
    OP_JZ     = 4'hA,
    OP_JMP    = 4'hB,
    OP_HALT   = 4'hC,
    OP_RSVD_D = 4'hD,
    OP_RSVD_E = 4'hE,
    OP_RSVD_F = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ST_FETCH    = 3'd0,
    ST_EXEC     = 3'd1,
    ST_WAIT_IN  = 3'd2,
    ST_WAIT_OUT = 3'd3,
    ST_HALT     = 3'd4
  } state_e;

  // Opcodes wider than the base encoding execute as NOP when any upper bit is set.
  function automatic opcode_e decode_op(input logic [OPCODE_BASE_WIDTH-1:0] low,
                                        input logic upper_nonzero);
    return upper_nonzero ? OP_NOP : opcode_e'(low);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_v2_alu.sv
// cpu_v2_alu: combinational ALU producing result, carry/borrow and zero.
// Revision: 1.0
`default_nettype none

module cpu_v2_alu
  import cpu_v2_pkg::*;
#(
  parameter int BUS_WIDTH = 8
) (
  input  opcode_e              op_i,
  input  logic [BUS_WIDTH-1:0] a_i,
  input  logic [BUS_WIDTH-1:0] b_i,
  output logic [BUS_WIDTH-1:0] result_o,
  output logic                 carry_o,
  output logic                 zero_o
);

  logic [BUS_WIDTH:0] sum;
  logic [BUS_WIDTH:0] diff;

  // The extra top bit is carry-out for addition and borrow (a<b) for subtraction.
  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = {1'b0, a_i} - {1'b0, b_i};

  always_comb begin
    result_o = '0;
    carry_o  = 1'b0;
    case (op_i)
      OP_ADD, OP_ADDI: {carry_o, result_o} = sum;
      OP_SUB:          {carry_o, result_o} = diff;
      OP_AND:          result_o = a_i & b_i;
      OP_OR:           result_o = a_i | b_i;
      OP_XOR:          result_o = a_i ^ b_i;
      default:         ;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

`default_nettype wire

// File: rtl/cpu_v2_core.sv
// cpu_v2_core: multi-cycle CPU with external combinational program ROM and
// ready/valid I/O ports. Revision: 1.0
`default_nettype none

module cpu_v2_core
  import cpu_v2_pkg::*;
#(
  parameter int BUS_WIDTH        = 8,
  parameter int REG_ADDR_WIDTH   = 3,
  parameter int INSTR_ADDR_WIDTH = 8,
  parameter int OPCODE_WIDTH     = 4,
  parameter int INSTR_WIDTH      = OPCODE_WIDTH + REG_ADDR_WIDTH + BUS_WIDTH
) (
  input  logic                        clk,
  input  logic                        n_reset,
  output logic [INSTR_ADDR_WIDTH-1:0] imem_addr,
  input  logic [INSTR_WIDTH-1:0]      imem_data,
  input  logic [BUS_WIDTH-1:0]        in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [BUS_WIDTH-1:0]        out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        halted,
  output logic [1:0]                  flags
);

  localparam int RA    = REG_ADDR_WIDTH;
  localparam int NREGS = 1 << RA;
  localparam int RD_HI = INSTR_WIDTH - OPCODE_WIDTH - 1;

  state_e                        state_q, state_d;
  logic [INSTR_ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [INSTR_WIDTH-1:0]        ir_q, ir_d;
  logic [BUS_WIDTH-1:0]          regs_q [NREGS];
  logic [BUS_WIDTH-1:0]          regs_d [NREGS];
  logic [1:0]                    flags_q, flags_d;
  logic [BUS_WIDTH-1:0]          out_data_q, out_data_d;
  logic                          out_valid_q, out_valid_d;
  logic                          in_ready_q, in_ready_d;

  logic [OPCODE_WIDTH-1:0]       opc;
  logic                          opc_upper_nz;
  opcode_e                       op;
  logic [RA-1:0]                 rd, ra, rb;
  logic [BUS_WIDTH-1:0]          imm;
  logic [BUS_WIDTH-1:0]          rd_val, ra_val, rb_val;
  logic [INSTR_ADDR_WIDTH-1:0]   pc_inc, jmp_target;
  logic [BUS_WIDTH-1:0]          alu_a, alu_b, alu_res;
  logic                          alu_c, alu_z;
  logic                          wr_en;
  logic [RA-1:0]                 wr_addr;
  logic [BUS_WIDTH-1:0]          wr_data;

  assign opc = ir_q[INSTR_WIDTH-1 -: OPCODE_WIDTH];
  assign rd  = ir_q[RD_HI -: RA];
  assign imm = ir_q[BUS_WIDTH-1:0];
  assign ra  = imm[2*RA-1 -: RA];
  assign rb  = imm[RA-1:0];

  generate
    if (OPCODE_WIDTH > OPCODE_BASE_WIDTH) begin : g_wide_opcode
      assign opc_upper_nz = |opc[OPCODE_WIDTH-1:OPCODE_BASE_WIDTH];
    end else begin : g_base_opcode
      assign opc_upper_nz = 1'b0;
    end
  endgenerate

  assign op = decode_op(opc[OPCODE_BASE_WIDTH-1:0], opc_upper_nz);

  // r0 is never written and is cleared by reset, so it always reads zero.
  assign rd_val = regs_q[rd];
  assign ra_val = regs_q[ra];
  assign rb_val = regs_q[rb];

  assign pc_inc     = pc_q + INSTR_ADDR_WIDTH'(1);
  assign jmp_target = imm[INSTR_ADDR_WIDTH-1:0];

  assign alu_a = (op == OP_ADDI) ? rd_val : ra_val;
  assign alu_b = (op == OP_ADDI) ? imm    : rb_val;

  cpu_v2_alu #(
    .BUS_WIDTH (BUS_WIDTH)
  ) u_alu (
    .op_i     (op),
    .a_i      (alu_a),
    .b_i      (alu_b),
    .result_o (alu_res),
    .carry_o  (alu_c),
    .zero_o   (alu_z)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    flags_d     = flags_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    wr_en       = 1'b0;
    wr_addr     = rd;
    wr_data     = alu_res;
    regs_d      = regs_q;

    case (state_q)
      ST_FETCH: begin
        ir_d    = imem_data;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        pc_d    = pc_inc;
        state_d = ST_FETCH;
        case (op)
          OP_LDI: begin
            wr_en   = 1'b1;
            wr_data = imm;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: begin
            wr_en   = 1'b1;
            flags_d = {alu_c, alu_z};
          end
          OP_IN: begin
            pc_d       = pc_q;
            in_ready_d = 1'b1;
            state_d    = ST_WAIT_IN;
          end
          OP_OUT: begin
            pc_d        = pc_q;
            out_data_d  = ra_val;
            out_valid_d = 1'b1;
            state_d     = ST_WAIT_OUT;
          end
          OP_JZ:   if (rd_val == '0) pc_d = jmp_target;
          OP_JMP:  pc_d = jmp_target;
          OP_HALT: begin
            pc_d    = pc_q;
            state_d = ST_HALT;
          end
          default: ;
        endcase
      end
      ST_WAIT_IN: begin
        if (in_valid && in_ready_q) begin
          wr_en      = 1'b1;
          wr_data    = in_data;
          pc_d       = pc_inc;
          in_ready_d = 1'b0;
          state_d    = ST_FETCH;
        end
      end
      ST_WAIT_OUT: begin
        if (out_ready) begin
          pc_d        = pc_inc;
          out_valid_d = 1'b0;
          state_d     = ST_FETCH;
        end
      end
      ST_HALT: ;
      default: state_d = ST_FETCH;
    endcase

    if (wr_en && (wr_addr != '0)) regs_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= ST_FETCH;
      pc_q        <= '0;
      ir_q        <= '0;
      regs_q      <= '{default: '0};
      flags_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      regs_q      <= regs_d;
      flags_q     <= flags_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign imem_addr = pc_q;
  assign in_ready  = in_ready_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign halted    = (state_q == ST_HALT);
  assign flags     = flags_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_v2_core.sv
// tb_cpu_v2_core: self-checking bench for cpu_v2_core with a ROM model and
// an output scoreboard. Revision: 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_cpu_v2_core;
  import cpu_v2_pkg::*;

  localparam int BW  = 8;
  localparam int RAW = 3;
  localparam int IAW = 8;
  localparam int OW  = 4;
  localparam int IW  = OW + RAW + BW;

  logic           clk = 1'b0;
  logic           n_reset = 1'b0;
  logic [IAW-1:0] imem_addr;
  logic [IW-1:0]  imem_data;
  logic [BW-1:0]  in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [BW-1:0]  out_data;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic           halted;
  logic [1:0]     flags;

  cpu_v2_core #(
    .BUS_WIDTH        (BW),
    .REG_ADDR_WIDTH   (RAW),
    .INSTR_ADDR_WIDTH (IAW),
    .OPCODE_WIDTH     (OW),
    .INSTR_WIDTH      (IW)
  ) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .halted    (halted),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  logic [IW-1:0] rom [256];
  assign imem_data = rom[imem_addr];

  int            n_tests = 0;
  int            n_fail  = 0;
  int            in_xfers = 0;
  logic [BW-1:0] exp_q [$];
  logic [BW-1:0] mon_exp;

  typedef struct {
    opcode_e       op;
    logic [BW-1:0] a;
    logic [BW-1:0] b;
    logic [BW-1:0] res;
    logic          c;
    logic          z;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] ins(input opcode_e op, input int rd, input logic [BW-1:0] imm);
    return {op, RAW'(rd), imm};
  endfunction

  function automatic logic [BW-1:0] rr(input int ra, input int rb);
    return {2'b00, RAW'(ra), RAW'(rb)};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = ins(OP_NOP, 0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_reset  = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
  endtask

  task automatic wait_halt(input int budget, input string name);
    int k;
    k = 0;
    while (!halted && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({name, "_halted"}, int'(halted), 1);
  endtask

  // Output scoreboard: a transfer happens at the posedge following a negedge
  // where valid and ready are both high.
  always begin
    @(negedge clk);
    #1;
    if (n_reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL out_unexpected: got 0x%0h, expected no output", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_data", int'(out_data), int'(mon_exp));
      end
    end
    if (n_reset && in_valid && in_ready) in_xfers++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            k;
    int            visits;
    logic [IAW-1:0] prev;
    logic          wrapped;

    vecs[0]  = '{OP_ADD,  8'd200, 8'd100, 8'd44,  1'b1, 1'b0};
    vecs[1]  = '{OP_SUB,  8'd100, 8'd200, 8'd156, 1'b1, 1'b0};
    vecs[2]  = '{OP_XOR,  8'd200, 8'd200, 8'd0,   1'b0, 1'b1};
    vecs[3]  = '{OP_ADD,  8'd1,   8'd2,   8'd3,   1'b0, 1'b0};
    vecs[4]  = '{OP_SUB,  8'd200, 8'd100, 8'd100, 1'b0, 1'b0};
    vecs[5]  = '{OP_AND,  8'hF0,  8'h3C,  8'h30,  1'b0, 1'b0};
    vecs[6]  = '{OP_OR,   8'h0F,  8'hA0,  8'hAF,  1'b0, 1'b0};
    vecs[7]  = '{OP_ADDI, 8'd250, 8'd10,  8'd4,   1'b1, 1'b0};
    vecs[8]  = '{OP_ADD,  8'd255, 8'd1,   8'd0,   1'b1, 1'b1};
    vecs[9]  = '{OP_AND,  8'h55,  8'hAA,  8'h00,  1'b0, 1'b1};
    vecs[10] = '{OP_SUB,  8'd5,   8'd5,   8'd0,   1'b0, 1'b1};

    // Reset while the core sits in WAIT_OUT.
    clear_rom();
    rom[0] = ins(OP_LDI, 1, 8'h77);
    rom[1] = ins(OP_OUT, 0, rr(1, 0));
    rom[2] = ins(OP_HALT, 0, 8'h00);
    out_ready = 1'b0;
    do_reset();
    #1;
    check("rst_imem_addr", int'(imem_addr), 0);
    check("rst_flags", int'(flags), 0);
    check("rst_halted", int'(halted), 0);
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("pre_rst_out_valid", int'(out_valid), 1);
    check("pre_rst_out_data", int'(out_data), 8'h77);
    @(negedge clk);
    n_reset = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_imem_addr", int'(imem_addr), 0);
    check("midrst_out_data", int'(out_data), 0);
    check("midrst_in_ready", int'(in_ready), 0);
    check("midrst_halted", int'(halted), 0);
    check("midrst_flags", int'(flags), 0);
    @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    check("postrst_fetch_addr", int'(imem_addr), 0);
    check("postrst_out_valid", int'(out_valid), 0);

    // Table-driven ALU vectors, each observed through an OUT instruction.
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      clear_rom();
      rom[0] = ins(OP_LDI, 1, vecs[i].a);
      rom[1] = ins(OP_LDI, 2, vecs[i].b);
      rom[2] = ins(OP_LDI, 3, vecs[i].a);
      if (vecs[i].op == OP_ADDI) rom[3] = ins(OP_ADDI, 3, vecs[i].b);
      else                       rom[3] = ins(vecs[i].op, 3, rr(1, 2));
      rom[4] = ins(OP_OUT, 0, rr(3, 0));
      rom[5] = ins(OP_HALT, 0, 8'h00);
      exp_q.push_back(vecs[i].res);
      do_reset();
      wait_halt(60, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_flags", i), int'(flags), int'({vecs[i].c, vecs[i].z}));
      check($sformatf("vec%0d_pending", i), exp_q.size(), 0);
      check($sformatf("vec%0d_halt_addr", i), int'(imem_addr), 5);
      exp_q.delete();
    end

    // Countdown loop.
    clear_rom();
    rom[0] = ins(OP_LDI, 1, 8'd3);
    rom[1] = ins(OP_ADDI, 1, 8'd255);
    rom[2] = ins(OP_JZ, 1, 8'd4);
    rom[3] = ins(OP_JMP, 0, 8'd1);
    rom[4] = ins(OP_HALT, 0, 8'h00);
    do_reset();
    visits = 0;
    prev = '0;
    k = 0;
    while (!halted && k < 100) begin
      @(negedge clk);
      if (imem_addr == 8'd1 && prev != 8'd1) visits++;
      prev = imem_addr;
      k++;
    end
    check("loop_halted", int'(halted), 1);
    check("loop_body_runs", visits, 3);
    check("loop_halt_addr", int'(imem_addr), 4);
    check("loop_flags", int'(flags), 2'b11);
    repeat (5) @(negedge clk);
    check("loop_still_halted", int'(halted), 1);
    check("loop_addr_held", int'(imem_addr), 4);

    // r0 stays zero and JZ r0 is always taken.
    clear_rom();
    rom[0] = ins(OP_LDI, 0, 8'd5);
    rom[1] = ins(OP_JZ, 0, 8'd4);
    rom[2] = ins(OP_LDI, 1, 8'h11);
    rom[3] = ins(OP_HALT, 0, 8'h00);
    rom[4] = ins(OP_OUT, 0, rr(0, 0));
    rom[5] = ins(OP_HALT, 0, 8'h00);
    exp_q.push_back(8'h00);
    do_reset();
    wait_halt(40, "r0");
    check("r0_halt_addr", int'(imem_addr), 5);
    check("r0_pending", exp_q.size(), 0);
    check("r0_flags", int'(flags), 0);
    exp_q.delete();

    // Input wait then output backpressure.
    clear_rom();
    rom[0] = ins(OP_IN, 2, 8'h00);
    rom[1] = ins(OP_OUT, 0, rr(2, 0));
    rom[2] = ins(OP_HALT, 0, 8'h00);
    out_ready = 1'b0;
    in_xfers = 0;
    do_reset();
    k = 0;
    while (!in_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      check($sformatf("in_ready_wait%0d", i), int'(in_ready), 1);
      @(negedge clk);
    end
    in_data  = 8'h5A;
    in_valid = 1'b1;
    check("in_ready_xfer", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h00;
    #2;
    check("in_ready_drop", int'(in_ready), 0);
    check("in_xfer_count", in_xfers, 1);
    exp_q.push_back(8'h5A);
    k = 0;
    while (!out_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_out_valid%0d", i), int'(out_valid), 1);
      check($sformatf("bp_out_data%0d", i), int'(out_data), 8'h5A);
      check($sformatf("bp_pc_held%0d", i), int'(imem_addr), 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #2;
    check("bp_out_valid_drop", int'(out_valid), 0);
    check("bp_out_data_kept", int'(out_data), 8'h5A);
    check("bp_pending", exp_q.size(), 0);
    wait_halt(20, "io");
    check("io_halt_addr", int'(imem_addr), 2);
    exp_q.delete();

    // PC wrap through an all-NOP ROM, then halt at 0x80.
    clear_rom();
    do_reset();
    prev = '0;
    wrapped = 1'b0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (prev == 8'hFF && imem_addr != 8'hFF) begin
        check("pc_wrap_value", int'(imem_addr), 0);
        wrapped = 1'b1;
        break;
      end
      prev = imem_addr;
    end
    check("pc_wrap_seen", int'(wrapped), 1);
    rom[8'h80] = ins(OP_HALT, 0, 8'h00);
    wait_halt(400, "wrap");
    check("wrap_halt_addr", int'(imem_addr), 8'h80);
    repeat (10) @(negedge clk);
    check("wrap_halt_sticky", int'(halted), 1);
    check("wrap_halt_addr_held", int'(imem_addr), 8'h80);
    do_reset();
    #1;
    check("wrap_reset_unhalt", int'(halted), 0);
    check("wrap_reset_addr", int'(imem_addr), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
